// File: rtl/uart_alu_pkg.sv
// Shared definitions for the UART <-> ALU byte-serial bridge.
package uart_alu_pkg;

  // Bridge FSM states: three receive phases, ALU settle, transmit.
  typedef enum logic [2:0] {
    RX_A  = 3'd0,
    RX_B  = 3'd1,
    RX_OP = 3'd2,
    WAIT  = 3'd3,
    TX    = 3'd4
  } state_t;

  // Width of one UART byte.
  localparam int BYTE_W = 8;

  // Width of a counter/index that must hold values up to n
  // (clog2(n)+1, never narrower than one bit).
  function automatic int cnt_width(input int n);
    if (n <= 1) begin
      return 1;
    end
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/uart_alu_bridge_frame_timer.sv
// Reloadable down-counter producing an expiry indication once it has run
// LOAD+1 cycles since the last clear. Used for the inter-byte timeout.
module frame_timer
  import uart_alu_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int LOAD   = 0,
  parameter bit ENABLE = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expire
);

  localparam logic [WIDTH-1:0] LOAD_VAL = WIDTH'(LOAD);

  logic [WIDTH-1:0] cnt_reg;
  logic [WIDTH-1:0] cnt_next;

  // Reload on clear, otherwise count down while running and saturate at zero.
  always_comb begin
    cnt_next = cnt_reg;
    if (clear) begin
      cnt_next = LOAD_VAL;
    end else if (run && (cnt_reg != '0)) begin
      cnt_next = cnt_reg - WIDTH'(1);
    end
  end

  // Counter register; a pop always reloads before the timer is first run,
  // so starting from zero out of reset is harmless.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  // Expiry is seen in the cycle the count sits at zero while running.
  assign expire = ENABLE && run && (cnt_reg == '0);

endmodule

// File: rtl/uart_alu_bridge.sv
// Byte-serial bridge: gathers little-endian operands A, B and an opcode
// byte from the RX FIFO, holds them on the ALU inputs, waits ALU_LAT
// cycles, then streams the captured result back to the TX FIFO LSB first.
module uart_alu_bridge
  import uart_alu_pkg::*;
#(
  parameter int REG_SIZE = 8,
  parameter int OP_SIZE  = 6,
  parameter int ALU_LAT  = 1,
  parameter int TIMEOUT  = 50000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       rx_empty,
  input  logic [7:0]                 r_data,
  output logic                       rd_uart,
  input  logic                       tx_full,
  output logic [7:0]                 w_data,
  output logic                       wr_uart,
  output logic signed [REG_SIZE-1:0] a,
  output logic signed [REG_SIZE-1:0] b,
  output logic [OP_SIZE-1:0]         op,
  input  logic signed [REG_SIZE-1:0] w,
  output logic                       busy,
  output logic                       done,
  output logic                       err_timeout
);

  localparam int NB    = REG_SIZE / BYTE_W;
  localparam int IDX_W = cnt_width(NB);
  localparam int LAT_W = cnt_width(ALU_LAT);
  localparam int TO_W  = cnt_width((TIMEOUT > 0) ? TIMEOUT : 1);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NB - 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(ALU_LAT - 1);

  state_t              state_reg, state_next;
  logic [IDX_W-1:0]    idx_reg, idx_next;
  logic [LAT_W-1:0]    lat_reg, lat_next;
  logic [REG_SIZE-1:0] a_reg, a_next;
  logic [REG_SIZE-1:0] b_reg, b_next;
  logic [OP_SIZE-1:0]  op_reg, op_next;
  logic [REG_SIZE-1:0] res_reg, res_next;
  logic                done_reg, done_next;
  logic                err_reg, err_next;

  logic                load_a;
  logic                load_b;
  logic                to_run;
  logic                to_clear;
  logic                to_expire;
  logic [7:0]          res_byte [NB];

  // Per-byte slot update for the operands and byte view of the result.
  // Only the slot addressed by idx takes the popped byte.
  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_byte
      localparam logic [IDX_W-1:0] SLOT = IDX_W'(gi);
      assign a_next[gi*BYTE_W +: BYTE_W] =
        (load_a && (idx_reg == SLOT)) ? r_data : a_reg[gi*BYTE_W +: BYTE_W];
      assign b_next[gi*BYTE_W +: BYTE_W] =
        (load_b && (idx_reg == SLOT)) ? r_data : b_reg[gi*BYTE_W +: BYTE_W];
      assign res_byte[gi] = res_reg[gi*BYTE_W +: BYTE_W];
    end
  endgenerate

  // Timeout runs only once a frame has started and never in WAIT/TX.
  assign to_run = ((state_reg == RX_A) && (idx_reg != '0)) ||
                  (state_reg == RX_B) || (state_reg == RX_OP);

  // Reload on any pop, any state change, or a forced resync to RX_A idx 0.
  assign to_clear = rd_uart || (state_next != state_reg) || err_next;

  frame_timer #(
    .WIDTH  (TO_W),
    .LOAD   ((TIMEOUT > 0) ? (TIMEOUT - 1) : 0),
    .ENABLE (TIMEOUT > 0)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (to_clear),
    .run    (to_run),
    .expire (to_expire)
  );

  // Next-state and strobe logic; a pop always takes priority over expiry.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    lat_next   = lat_reg;
    op_next    = op_reg;
    res_next   = res_reg;
    done_next  = 1'b0;
    err_next   = 1'b0;
    rd_uart    = 1'b0;
    wr_uart    = 1'b0;
    load_a     = 1'b0;
    load_b     = 1'b0;

    case (state_reg)
      RX_A: begin
        rd_uart = reset && !rx_empty;
        if (rd_uart) begin
          load_a = 1'b1;
          if (idx_reg == IDX_LAST) begin
            state_next = RX_B;
            idx_next   = '0;
          end else begin
            idx_next = idx_reg + IDX_W'(1);
          end
        end else if (to_expire) begin
          state_next = RX_A;
          idx_next   = '0;
          err_next   = 1'b1;
        end
      end

      RX_B: begin
        rd_uart = reset && !rx_empty;
        if (rd_uart) begin
          load_b = 1'b1;
          if (idx_reg == IDX_LAST) begin
            state_next = RX_OP;
            idx_next   = '0;
          end else begin
            idx_next = idx_reg + IDX_W'(1);
          end
        end else if (to_expire) begin
          state_next = RX_A;
          idx_next   = '0;
          err_next   = 1'b1;
        end
      end

      RX_OP: begin
        rd_uart = reset && !rx_empty;
        if (rd_uart) begin
          op_next    = r_data[OP_SIZE-1:0];
          state_next = WAIT;
          idx_next   = '0;
          lat_next   = '0;
        end else if (to_expire) begin
          state_next = RX_A;
          idx_next   = '0;
          err_next   = 1'b1;
        end
      end

      WAIT: begin
        if (lat_reg == LAT_LAST) begin
          res_next   = w;
          state_next = TX;
          idx_next   = '0;
        end else begin
          lat_next = lat_reg + LAT_W'(1);
        end
      end

      TX: begin
        wr_uart = reset && !tx_full;
        if (wr_uart) begin
          if (idx_reg == IDX_LAST) begin
            state_next = RX_A;
            idx_next   = '0;
            done_next  = 1'b1;
          end else begin
            idx_next = idx_reg + IDX_W'(1);
          end
        end
      end

      default: begin
        state_next = RX_A;
        idx_next   = '0;
      end
    endcase
  end

  // Select the result byte addressed by idx for transmission.
  always_comb begin
    w_data = '0;
    for (int i = 0; i < NB; i++) begin
      if (idx_reg == IDX_W'(i)) begin
        w_data = res_byte[i];
      end
    end
  end

  // State and datapath registers; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= RX_A;
      idx_reg   <= '0;
      lat_reg   <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      op_reg    <= '0;
      res_reg   <= '0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      lat_reg   <= lat_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      op_reg    <= op_next;
      res_reg   <= res_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
    end
  end

  assign a           = a_reg;
  assign b           = b_reg;
  assign op          = op_reg;
  assign done        = done_reg;
  assign err_timeout = err_reg;
  assign busy        = !((state_reg == RX_A) && (idx_reg == '0));

endmodule

// File: tb/tb_uart_alu_bridge.sv
// Self-checking bench for uart_alu_bridge: a 16-bit instance (ALU_LAT=2,
// TIMEOUT=20) and a 32-bit instance, fed from RX byte queues, with a
// scoreboard of expected TX bytes.
module tb_uart_alu_bridge;

  localparam int TO  = 20;
  localparam int LAT = 2;
  localparam int NB  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic               rx_empty16, tx_full16, rd16, wr16, busy16, done16, err16;
  logic [7:0]         r_data16, w_data16;
  logic signed [15:0] a16, b16, w16;
  logic [5:0]         op16;

  logic               rx_empty32, tx_full32, rd32, wr32, busy32, done32, err32;
  logic [7:0]         r_data32, w_data32;
  logic signed [31:0] a32, b32, w32;
  logic [5:0]         op32;

  // Bench ALUs: opcode 0x20 adds, anything else subtracts; 32-bit one subtracts.
  assign w16 = (op16 == 6'h20) ? (a16 + b16) : (a16 - b16);
  assign w32 = a32 - b32;

  uart_alu_bridge #(.REG_SIZE(16), .OP_SIZE(6), .ALU_LAT(LAT), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .rx_empty(rx_empty16), .r_data(r_data16), .rd_uart(rd16),
    .tx_full(tx_full16), .w_data(w_data16), .wr_uart(wr16), .a(a16), .b(b16), .op(op16),
    .w(w16), .busy(busy16), .done(done16), .err_timeout(err16)
  );

  uart_alu_bridge #(.REG_SIZE(32), .OP_SIZE(6), .ALU_LAT(1), .TIMEOUT(0)) dut32 (
    .clk(clk), .reset(reset), .rx_empty(rx_empty32), .r_data(r_data32), .rd_uart(rd32),
    .tx_full(tx_full32), .w_data(w_data32), .wr_uart(wr32), .a(a32), .b(b32), .op(op32),
    .w(w32), .busy(busy32), .done(done32), .err_timeout(err32)
  );

  logic       use32;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         pop_cyc_q[$];
  int         cyc, pop_cnt, done_cnt, err_cnt, done_cyc, err_cyc;
  int         n_checks, n_fail;

  // Present the head of the RX queue to the active DUT only.
  task automatic drive_rx();
    rx_empty16 = 1'b1; r_data16 = 8'h00;
    rx_empty32 = 1'b1; r_data32 = 8'h00;
    if (rx_q.size() > 0) begin
      if (use32) begin rx_empty32 = 1'b0; r_data32 = rx_q[0]; end
      else       begin rx_empty16 = 1'b0; r_data16 = rx_q[0]; end
    end
  endtask

  // One clock: sample strobes at the falling edge, advance the FIFO model after the rising edge.
  task automatic cycle();
    logic rd, wr, dn, er;
    logic [7:0] wd;
    @(negedge clk);
    rd = use32 ? rd32 : rd16;
    wr = use32 ? wr32 : wr16;
    wd = use32 ? w_data32 : w_data16;
    dn = use32 ? done32 : done16;
    er = use32 ? err32 : err16;
    if (rd) begin pop_cnt++; pop_cyc_q.push_back(cyc); end
    if (wr) begin got_q.push_back(wd); $display("cycle %0d: tx byte %02h", cyc, wd); end
    if (dn) begin done_cnt++; done_cyc = cyc; end
    if (er) begin err_cnt++; err_cyc = cyc; end
    @(posedge clk);
    #1;
    if (rd && rx_q.size() > 0) rx_q.delete(0);
    drive_rx();
    cyc++;
  endtask

  function automatic logic [15:0] alu16(logic [15:0] x, logic [15:0] y, logic [7:0] o);
    return (o[5:0] == 6'h20) ? (x + y) : (x - y);
  endfunction

  // Queue one 16-bit frame and push its expected result bytes to the scoreboard.
  task automatic send_frame16(input logic [15:0] x, input logic [15:0] y, input logic [7:0] o);
    logic [15:0] r;
    r = alu16(x, y, o);
    rx_q.push_back(x[7:0]); rx_q.push_back(x[15:8]);
    rx_q.push_back(y[7:0]); rx_q.push_back(y[15:8]);
    rx_q.push_back(o);
    exp_q.push_back(r[7:0]); exp_q.push_back(r[15:8]);
    drive_rx();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    rx_q.push_back(8'h55);
    drive_rx();
    cycle(); cycle();
    n_checks++; if (rd16 !== 1'b0) begin n_fail++; $display("FAIL reset_rd_gated: got %b want 0", rd16); end
    rx_q.delete();
    drive_rx();
    reset = 1'b1;
    cycle();
    n_checks++; if (busy16 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy16); end
    n_checks++; if (done16 !== 1'b0 || err16 !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: done %b err %b want 0 0", done16, err16); end
    n_checks++; if (a16 !== 16'h0 || b16 !== 16'h0 || op16 !== 6'h0) begin n_fail++; $display("FAIL reset_operands: a %h b %h op %h want 0", a16, b16, op16); end
    n_checks++; if (wr16 !== 1'b0 || pop_cnt !== 0) begin n_fail++; $display("FAIL reset_strobes: wr %b pops %0d want 0 0", wr16, pop_cnt); end
  endtask

  task automatic test_basic();
    int base_done, first_pop, guard;
    logic [7:0] g, e;
    base_done = done_cnt;
    first_pop = pop_cyc_q.size();
    rx_q.push_back(8'h34); rx_q.push_back(8'h12); rx_q.push_back(8'h78);
    rx_q.push_back(8'h56); rx_q.push_back(8'h20);
    exp_q.push_back(8'hAC); exp_q.push_back(8'h68);
    drive_rx();
    guard = 0;
    while (done_cnt == base_done && guard < 100) begin cycle(); guard++; end
    n_checks++; if (done_cnt !== base_done + 1) begin n_fail++; $display("FAIL basic_done: got %0d pulses want 1", done_cnt - base_done); end
    n_checks++; if (a16 !== 16'h1234 || b16 !== 16'h5678 || op16 !== 6'h20) begin n_fail++; $display("FAIL basic_operands: a %h b %h op %h want 1234 5678 20", a16, b16, op16); end
    n_checks++; if (pop_cyc_q.size() > first_pop && done_cyc - pop_cyc_q[first_pop] !== 2*NB+1+LAT+NB) begin n_fail++; $display("FAIL basic_latency: got %0d want %0d", done_cyc - pop_cyc_q[first_pop], 2*NB+1+LAT+NB); end
    n_checks++; if (got_q.size() !== 2) begin n_fail++; $display("FAIL basic_push_count: got %0d want 2", got_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_checks++; if (g !== e) begin n_fail++; $display("FAIL basic_tx_byte: got %02h want %02h", g, e); end
    end
    cycle();
    n_checks++; if (done16 !== 1'b0) begin n_fail++; $display("FAIL basic_done_width: done still %b", done16); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_tx_stall();
    int base_pop, base_done, guard, pushes_seen;
    logic [7:0] g, e;
    base_pop = pop_cnt; base_done = done_cnt;
    tx_full16 = 1'b1;
    send_frame16(16'h0005, 16'h0003, 8'h21);
    send_frame16(16'h0010, 16'h0020, 8'h20);
    guard = 0;
    while (pop_cnt - base_pop < 5 && guard < 30) begin cycle(); guard++; end
    pushes_seen = 0;
    for (int i = 0; i < LAT + 10; i++) begin
      cycle();
      if (got_q.size() != 0) pushes_seen++;
    end
    n_checks++; if (pushes_seen !== 0) begin n_fail++; $display("FAIL stall_no_push: got %0d push cycles want 0", pushes_seen); end
    n_checks++; if (pop_cnt - base_pop !== 5) begin n_fail++; $display("FAIL stall_rx_held: got %0d pops want 5", pop_cnt - base_pop); end
    tx_full16 = 1'b0;
    cycle();
    n_checks++; if (got_q.size() !== 1) begin n_fail++; $display("FAIL stall_first_push: got %0d bytes want 1", got_q.size()); end
    guard = 0;
    while (done_cnt - base_done < 2 && guard < 80) begin cycle(); guard++; end
    n_checks++; if (done_cnt - base_done !== 2 || got_q.size() !== 4) begin n_fail++; $display("FAIL stall_frames: done %0d bytes %0d want 2 4", done_cnt - base_done, got_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_checks++; if (g !== e) begin n_fail++; $display("FAIL stall_tx_byte: got %02h want %02h", g, e); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back();
    int base, base_done, guard;
    logic ok1, ok2;
    logic [7:0] g, e;
    base = pop_cyc_q.size(); base_done = done_cnt;
    send_frame16(16'h000A, 16'h0005, 8'h20);
    send_frame16(16'h8000, 16'h0001, 8'h22);
    guard = 0;
    while (done_cnt - base_done < 2 && guard < 80) begin cycle(); guard++; end
    n_checks++; if (pop_cyc_q.size() - base !== 10) begin n_fail++; $display("FAIL b2b_pops: got %0d want 10", pop_cyc_q.size() - base); end
    ok1 = 1'b1; ok2 = 1'b1;
    if (pop_cyc_q.size() - base >= 10) begin
      for (int i = 0; i < 4; i++) begin
        if (pop_cyc_q[base+i+1] - pop_cyc_q[base+i] != 1) ok1 = 1'b0;
        if (pop_cyc_q[base+i+6] - pop_cyc_q[base+i+5] != 1) ok2 = 1'b0;
      end
    end
    n_checks++; if (ok1 !== 1'b1 || ok2 !== 1'b1) begin n_fail++; $display("FAIL b2b_consecutive: frame1 %b frame2 %b want 1 1", ok1, ok2); end
    n_checks++; if (done_cnt - base_done !== 2 || got_q.size() !== 2*NB) begin n_fail++; $display("FAIL b2b_counts: done %0d bytes %0d want 2 4", done_cnt - base_done, got_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_checks++; if (g !== e) begin n_fail++; $display("FAIL b2b_tx_byte: got %02h want %02h", g, e); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_timeout();
    int base_err, base_pop, base_done, guard, pop_at;
    logic [7:0] g, e;
    base_err = err_cnt; base_pop = pop_cyc_q.size();
    rx_q.push_back(8'h11);
    drive_rx();
    guard = 0;
    while (err_cnt == base_err && guard < 60) begin cycle(); guard++; end
    pop_at = (pop_cyc_q.size() > base_pop) ? pop_cyc_q[base_pop] : -100;
    n_checks++; if (err_cnt !== base_err + 1) begin n_fail++; $display("FAIL timeout_pulse: got %0d pulses want 1", err_cnt - base_err); end
    n_checks++; if ((err_cyc - 1) - pop_at !== TO) begin n_fail++; $display("FAIL timeout_delay: got %0d cycles want %0d", (err_cyc - 1) - pop_at, TO); end
    n_checks++; if (busy16 !== 1'b0 || a16[7:0] !== 8'h11) begin n_fail++; $display("FAIL timeout_resync: busy %b a_lo %02h want 0 11", busy16, a16[7:0]); end
    cycle(); cycle(); cycle();
    n_checks++; if (err_cnt !== base_err + 1) begin n_fail++; $display("FAIL timeout_width: got %0d pulses want 1", err_cnt - base_err); end
    base_done = done_cnt;
    send_frame16(16'h00FF, 16'h0001, 8'h20);
    guard = 0;
    while (done_cnt == base_done && guard < 80) begin cycle(); guard++; end
    n_checks++; if (done_cnt !== base_done + 1 || got_q.size() !== NB) begin n_fail++; $display("FAIL timeout_refresh: done %0d bytes %0d want 1 2", done_cnt - base_done, got_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_checks++; if (g !== e) begin n_fail++; $display("FAIL timeout_tx_byte: got %02h want %02h", g, e); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_in_tx();
    int guard, base_done;
    logic [7:0] g, e;
    base_done = done_cnt;
    send_frame16(16'h0001, 16'h0002, 8'h20);
    guard = 0;
    while (got_q.size() == 0 && guard < 40) begin cycle(); guard++; end
    n_checks++; if (got_q.size() !== 1) begin n_fail++; $display("FAIL rst_tx_first: got %0d bytes want 1", got_q.size()); end
    if (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_checks++; if (g !== e) begin n_fail++; $display("FAIL rst_tx_byte: got %02h want %02h", g, e); end
    end
    reset = 1'b0;
    #1;
    n_checks++; if (wr16 !== 1'b0) begin n_fail++; $display("FAIL rst_tx_wr_gated: got %b want 0", wr16); end
    cycle();
    reset = 1'b1;
    n_checks++; if (busy16 !== 1'b0 || a16 !== 16'h0 || b16 !== 16'h0 || op16 !== 6'h0) begin n_fail++; $display("FAIL rst_tx_clear: busy %b a %h b %h op %h want 0", busy16, a16, b16, op16); end
    for (int i = 0; i < 10; i++) cycle();
    n_checks++; if (got_q.size() !== 0 || done_cnt !== base_done) begin n_fail++; $display("FAIL rst_tx_abandon: bytes %0d done %0d want 0 0", got_q.size(), done_cnt - base_done); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_sub32();
    int guard, base_done;
    logic [7:0] g, e;
    use32 = 1'b1;
    base_done = done_cnt;
    rx_q.push_back(8'h00); rx_q.push_back(8'h00); rx_q.push_back(8'h00); rx_q.push_back(8'h80);
    rx_q.push_back(8'hFF); rx_q.push_back(8'hFF); rx_q.push_back(8'hFF); rx_q.push_back(8'hFF);
    rx_q.push_back(8'h01);
    exp_q.push_back(8'h01); exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'h80);
    drive_rx();
    guard = 0;
    while (done_cnt == base_done && guard < 80) begin cycle(); guard++; end
    n_checks++; if (done_cnt !== base_done + 1 || got_q.size() !== 4) begin n_fail++; $display("FAIL sub32_frame: done %0d bytes %0d want 1 4", done_cnt - base_done, got_q.size()); end
    n_checks++; if (a32 !== 32'h80000000 || b32 !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL sub32_operands: a %h b %h", a32, b32); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_checks++; if (g !== e) begin n_fail++; $display("FAIL sub32_tx_byte: got %02h want %02h", g, e); end
    end
    cycle();
    n_checks++; if (busy32 !== 1'b0 || err32 !== 1'b0) begin n_fail++; $display("FAIL sub32_idle: busy %b err %b want 0 0", busy32, err32); end
    got_q.delete(); exp_q.delete();
    use32 = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    cyc = 0; pop_cnt = 0; done_cnt = 0; err_cnt = 0; done_cyc = 0; err_cyc = 0;
    use32 = 1'b0; tx_full16 = 1'b0; tx_full32 = 1'b0; reset = 1'b0;
    drive_rx();
    test_reset();
    test_basic();
    test_tx_stall();
    test_back_to_back();
    test_timeout();
    test_reset_in_tx();
    test_sub32();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
